// File: rtl/button_pio_db.sv
// button_pio_db: Avalon-MM push-button/switch input port.
// Synchronises up to 32 inputs, optionally debounces them, captures rising and/or
// falling edges per channel with write-1-to-clear, and raises a maskable level irq.
// Build option: define BUTTON_PIO_DEBOUNCE_EN to build the per-channel debounce
// counters; otherwise the debounced value is the synchronised input itself.

module button_pio_db #(
  parameter int unsigned WIDTH      = 3,
  parameter int unsigned DB_CYCLES  = 50000,
  parameter logic        INIT_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [2:0] AddrData  = 3'd0;
  localparam logic [2:0] AddrRaw   = 3'd1;
  localparam logic [2:0] AddrMask  = 3'd2;
  localparam logic [2:0] AddrEdge  = 3'd3;
  localparam logic [2:0] AddrRise  = 3'd4;
  localparam logic [2:0] AddrFall  = 3'd5;

  logic [WIDTH-1:0] sync0;
  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] db;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] detect;
  logic [WIDTH-1:0] w1c_mask;
  logic [WIDTH-1:0] wdata;
  logic             wr_en;
  logic [31:0]      rd_mux;

  // Upper write-data bits beyond WIDTH are intentionally ignored.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  assign wr_en = chipselect && !write_n;
  assign wdata = writedata[WIDTH-1:0];

  // Two-stage synchroniser for the asynchronous button inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync0 <= {WIDTH{INIT_LEVEL}};
      sync1 <= {WIDTH{INIT_LEVEL}};
    end else begin
      sync0 <= in_port;
      sync1 <= sync0;
    end
  end

`ifdef BUTTON_PIO_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DB_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES - 1);

  logic [CntW-1:0] cnt [WIDTH];

  // Per-channel debounce: db follows sync1 only after DB_CYCLES consecutive mismatches;
  // any agreement in between restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db <= {WIDTH{INIT_LEVEL}};
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (sync1[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CntMax) begin
          db[i]  <= sync1[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  // Without debounce the edge logic runs directly on the synchronised input.
  localparam int unsigned unused_db_cycles = DB_CYCLES;
  assign db = sync1;
`endif

  assign detect   = (db & ~prev & rise_en) | (~db & prev & fall_en);
  assign w1c_mask = (wr_en && (address == AddrEdge)) ? wdata : '0;

  // Previous debounced state for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev <= {WIDTH{INIT_LEVEL}};
    end else begin
      prev <= db;
    end
  end

  // Edge capture: a new edge in the same cycle as a W1C of that bit wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_capture <= '0;
    end else begin
      edge_capture <= (edge_capture & ~w1c_mask) | detect;
    end
  end

  // Software-writable control registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= '0;
      rise_en  <= '1;
      fall_en  <= '0;
    end else if (wr_en) begin
      if (address == AddrMask) irq_mask <= wdata;
      if (address == AddrRise) rise_en  <= wdata;
      if (address == AddrFall) fall_en  <= wdata;
    end
  end

  // Read mux, zero-extended to the bus width.
  always_comb begin
    rd_mux = '0;
    case (address)
      AddrData: rd_mux[WIDTH-1:0] = db;
      AddrRaw:  rd_mux[WIDTH-1:0] = sync1;
      AddrMask: rd_mux[WIDTH-1:0] = irq_mask;
      AddrEdge: rd_mux[WIDTH-1:0] = edge_capture;
      AddrRise: rd_mux[WIDTH-1:0] = rise_en;
      AddrFall: rd_mux[WIDTH-1:0] = fall_en;
      default:  rd_mux = '0;
    endcase
  end

  // Registered read data, updated every cycle regardless of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_button_pio_db.sv
// Directed self-checking bench for button_pio_db (WIDTH=3, DB_CYCLES=4, INIT_LEVEL=0).
// Expected latencies follow the build option BUTTON_PIO_DEBOUNCE_EN.

module tb_button_pio_db;

  localparam int unsigned Width    = 3;
  localparam int unsigned DbCycles = 4;
`ifdef BUTTON_PIO_DEBOUNCE_EN
  // in_port step to edge_capture/irq: 2 sync + DB_CYCLES debounce + 1 capture.
  localparam int Lat = 3 + DbCycles;
`else
  localparam int Lat = 3;
`endif

  logic             clk;
  logic             reset_n;
  logic [2:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [Width-1:0] in_port;
  logic [31:0]      readdata;
  logic             irq;

  int n_checks;
  int n_fail;
  logic [31:0] rd;

  button_pio_db #(
    .WIDTH     (Width),
    .DB_CYCLES (DbCycles),
    .INIT_LEVEL(1'b0)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address = a;
    tick();
    d = readdata;
  endtask

  task automatic do_reset();
    in_port    = '0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    reset_n    = 1'b0;
    #12;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] exp_tab [8];
    exp_tab = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h7, 32'h0, 32'h0, 32'h0};
    do_reset();
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), rd);
      n_checks++;
      if (rd !== exp_tab[a]) begin
        n_fail++;
        $display("FAIL reset_read addr%0d: got %h expected %h", a, rd, exp_tab[a]);
      end
    end
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_irq: got %b expected 0", irq);
    end
    // Reset asserted mid-count: readdata clears asynchronously, then the count restarts.
    bus_read(3'd4, rd);
    in_port = 3'b001;
    tick();
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (readdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_async_readdata: got %h expected 0", readdata);
    end
    @(negedge clk);
    reset_n = 1'b1;
    address = 3'd0;
    for (int k = 1; k <= Lat; k++) begin
      tick();
      n_checks++;
      if (readdata !== ((k >= Lat) ? 32'h1 : 32'h0)) begin
        n_fail++;
        $display("FAIL reset_midcount_data k=%0d: got %h expected %h", k, readdata,
                 (k >= Lat) ? 32'h1 : 32'h0);
      end
    end
  endtask

  task automatic test_debounce();
    do_reset();
    address = 3'd0;
    in_port = 3'b001;
    for (int k = 1; k <= Lat + 1; k++) begin
      tick();
      n_checks++;
      if (readdata !== ((k >= Lat) ? 32'h1 : 32'h0)) begin
        n_fail++;
        $display("FAIL debounce_data k=%0d: got %h expected %h", k, readdata,
                 (k >= Lat) ? 32'h1 : 32'h0);
      end
    end
    bus_read(3'd1, rd);
    n_checks++;
    if (rd !== 32'h1) begin
      n_fail++;
      $display("FAIL debounce_raw: got %h expected 1", rd);
    end
    bus_read(3'd3, rd);
    n_checks++;
    if (rd !== 32'h1) begin
      n_fail++;
      $display("FAIL debounce_capture: got %h expected 1", rd);
    end
  endtask

  task automatic test_glitch();
    do_reset();
`ifdef BUTTON_PIO_DEBOUNCE_EN
    // 3-cycle pulse is one short of DB_CYCLES and must be rejected.
    in_port = 3'b010;
    tick();
    tick();
    tick();
    in_port = 3'b000;
    repeat (10) tick();
    bus_read(3'd0, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL glitch_data: got %h expected 0", rd);
    end
    bus_read(3'd3, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL glitch_capture: got %h expected 0", rd);
    end
`else
    // Without debounce a single-cycle glitch is a real edge.
    in_port = 3'b001;
    tick();
    in_port = 3'b000;
    repeat (5) tick();
    bus_read(3'd3, rd);
    n_checks++;
    if (rd !== 32'h1) begin
      n_fail++;
      $display("FAIL glitch_capture: got %h expected 1", rd);
    end
`endif
  endtask

  task automatic test_rise_w1c();
    do_reset();
    bus_write(3'd2, 32'h1);
    bus_read(3'd2, rd);
    n_checks++;
    if (rd !== 32'h1) begin
      n_fail++;
      $display("FAIL mask_readback: got %h expected 1", rd);
    end
    in_port = 3'b001;
    repeat (Lat - 1) tick();
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL rise_irq_early: got %b expected 0", irq);
    end
    tick();
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL rise_irq: got %b expected 1", irq);
    end
    bus_write(3'd3, 32'h2);
    bus_read(3'd3, rd);
    n_checks++;
    if (rd !== 32'h1 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL w1c_other_bit: got %h irq %b expected 1 irq 1", rd, irq);
    end
    bus_write(3'd2, 32'h0);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL mask_off_irq: got %b expected 0", irq);
    end
    bus_write(3'd2, 32'h1);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL mask_on_irq: got %b expected 1", irq);
    end
    bus_write(3'd3, 32'h1);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL w1c_irq: got %b expected 0", irq);
    end
    bus_read(3'd3, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL w1c_capture: got %h expected 0", rd);
    end
  endtask

  task automatic test_fall_both();
    do_reset();
    bus_write(3'd4, 32'h0);
    bus_write(3'd5, 32'h4);
    bus_read(3'd5, rd);
    n_checks++;
    if (rd !== 32'h4) begin
      n_fail++;
      $display("FAIL fall_en_readback: got %h expected 4", rd);
    end
    in_port = 3'b100;
    repeat (Lat + 2) tick();
    bus_read(3'd3, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL fall_on_press: got %h expected 0", rd);
    end
    in_port = 3'b000;
    repeat (Lat + 2) tick();
    bus_read(3'd3, rd);
    n_checks++;
    if (rd !== 32'h4) begin
      n_fail++;
      $display("FAIL fall_on_release: got %h expected 4", rd);
    end
    bus_write(3'd3, 32'h4);
    bus_write(3'd4, 32'h4);
    in_port = 3'b100;
    repeat (Lat + 2) tick();
    bus_read(3'd3, rd);
    n_checks++;
    if (rd !== 32'h4) begin
      n_fail++;
      $display("FAIL both_on_press: got %h expected 4", rd);
    end
    bus_write(3'd3, 32'h4);
    in_port = 3'b000;
    repeat (Lat + 2) tick();
    bus_read(3'd3, rd);
    n_checks++;
    if (rd !== 32'h4) begin
      n_fail++;
      $display("FAIL both_on_release: got %h expected 4", rd);
    end
  endtask

  task automatic test_collision();
    do_reset();
    address = 3'd3;
    in_port = 3'b001;
    repeat (Lat - 1) tick();
    n_checks++;
    if (readdata !== 32'h0) begin
      n_fail++;
      $display("FAIL collision_pre: got %h expected 0", readdata);
    end
    // W1C lands on the same edge that captures the new rise.
    bus_write(3'd3, 32'h1);
    bus_read(3'd3, rd);
    n_checks++;
    if (rd !== 32'h1) begin
      n_fail++;
      $display("FAIL collision_set_wins: got %h expected 1", rd);
    end
    bus_write(3'd3, 32'h1);
    bus_read(3'd3, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL collision_later_clear: got %h expected 0", rd);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_debounce();
    test_glitch();
    test_rise_w1c();
    test_fall_both();
    test_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
